// File: rtl/wb_fairness_monitor_if.sv
// Wishbone-classic request/acknowledge bundle observed by wb_fairness_monitor.
interface wb_fairness_monitor_if #(
  parameter int ADR_W = 30,
  parameter int DAT_W = 32,
  parameter int SEL_W = 4
);
  logic             cyc;
  logic             stb;
  logic             we;
  logic [SEL_W-1:0] sel;
  logic [ADR_W-1:0] adr;
  logic [DAT_W-1:0] dat_w;
  logic             ack;

  modport master  (output cyc, stb, we, sel, adr, dat_w, input ack);
  modport slave   (input cyc, stb, we, sel, adr, dat_w, output ack);
  modport monitor (input cyc, stb, we, sel, adr, dat_w, ack);
endinterface

// File: rtl/wb_fairness_monitor.sv
// Passive Wishbone-classic and trap-nesting monitor with sticky protocol-error flags.
// Define WBMON_ASSUME_EN together with FORMAL to turn every error condition into an assumption.
//
// state | meaning
// IDLE  | no strobe outstanding, wait_cnt is 0
// WAIT  | strobe accepted without ack, request captured for stability checks
module wb_fairness_monitor #(
  parameter int ADR_W    = 30,
  parameter int DAT_W    = 32,
  parameter int SEL_W    = 4,
  parameter int CNT_W    = 4,
  parameter int MIN_LAT  = 1,
  parameter int MAX_WAIT = 4,
  parameter int NEST_W   = 2,
  parameter int MAX_NEST = 1,
  parameter int TXN_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  wb_fairness_monitor_if.monitor bus,
  input  logic                  rvfi_valid,
  input  logic                  rvfi_trap,
  input  logic [31:0]           rvfi_insn,
  output logic [CNT_W-1:0]      wait_cnt,
  output logic [NEST_W-1:0]     nest_depth,
  output logic [TXN_W-1:0]      txn_count,
  output logic                  err_timeout,
  output logic                  err_early_ack,
  output logic                  err_unstable,
  output logic                  err_nest
);
  localparam logic [31:0]       MRET        = 32'h3020_0073;
  localparam logic [CNT_W-1:0]  WAIT_SAT    = '1;
  localparam logic [CNT_W-1:0]  TIMEOUT_CNT = CNT_W'(MAX_WAIT - 1);
  localparam logic [CNT_W-1:0]  MIN_CNT     = CNT_W'(MIN_LAT);
  localparam logic [NEST_W-1:0] NEST_MAX    = NEST_W'(MAX_NEST);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t           state;
  logic [ADR_W-1:0] cap_adr;
  logic             cap_we;
  logic [SEL_W-1:0] cap_sel;
  logic [DAT_W-1:0] cap_dat;

  logic req;
  logic req_changed;
  logic set_timeout;
  logic set_early;
  logic set_unstable;
  logic set_nest;
  logic is_mret;

  assign req = bus.cyc & bus.stb;
  // Write data only matters for writes; a change of we itself is already caught.
  assign req_changed = (bus.adr != cap_adr) || (bus.we != cap_we) || (bus.sel != cap_sel) ||
                       (cap_we && (bus.dat_w != cap_dat));
  assign set_timeout  = req & ~bus.ack & (wait_cnt == TIMEOUT_CNT);
  assign set_early    = bus.ack & (~req | (wait_cnt < MIN_CNT));
  assign set_unstable = (state == WAIT) & req & req_changed;
  assign is_mret      = (rvfi_insn == MRET);
  assign set_nest     = rvfi_valid & rvfi_trap & (nest_depth == NEST_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cap_adr       <= '0;
      cap_we        <= 1'b0;
      cap_sel       <= '0;
      cap_dat       <= '0;
      wait_cnt      <= '0;
      txn_count     <= '0;
      err_timeout   <= 1'b0;
      err_early_ack <= 1'b0;
      err_unstable  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            cap_adr <= bus.adr;
            cap_we  <= bus.we;
            cap_sel <= bus.sel;
            cap_dat <= bus.dat_w;
            if (!bus.ack) state <= WAIT;
          end
        end
        WAIT: begin
          if (!req || bus.ack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (req && !bus.ack) begin
        if (wait_cnt != WAIT_SAT) wait_cnt <= wait_cnt + CNT_W'(1);
      end else begin
        wait_cnt <= '0;
      end

      if (req && bus.ack) txn_count <= txn_count + TXN_W'(1);

      if (set_timeout)  err_timeout   <= 1'b1;
      if (set_early)    err_early_ack <= 1'b1;
      if (set_unstable) err_unstable  <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      nest_depth <= '0;
      err_nest   <= 1'b0;
    end else if (rvfi_valid) begin
      if (rvfi_trap) begin
        if (set_nest) err_nest <= 1'b1;
        else          nest_depth <= nest_depth + NEST_W'(1);
      end else if (is_mret && (nest_depth != '0)) begin
        nest_depth <= nest_depth - NEST_W'(1);
      end
    end
  end

`ifdef WBMON_ASSUME_EN
`ifdef FORMAL
  always_comb begin
    if (rst) begin
      assume (!set_timeout);
      assume (!set_early);
      assume (!set_unstable);
      assume (!set_nest);
    end
  end
`endif
`else
  // Pure observer: flags report violations, nothing constrains the environment.
`endif

endmodule

// File: tb/tb_wb_fairness_monitor.sv
// Self-checking bench for wb_fairness_monitor: directed vector table, corner sequences, random vs model.
module tb_wb_fairness_monitor;
  localparam int ADR_W = 30, DAT_W = 32, SEL_W = 4, CNT_W = 4;
  localparam int MIN_LAT = 1, MAX_WAIT = 4, NEST_W = 2, MAX_NEST = 1, TXN_W = 4;
  localparam logic [31:0] MRET = 32'h3020_0073;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  typedef struct {
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [29:0] adr;
    logic [31:0] dat;
    logic        ack, valid, trap;
    logic [31:0] insn;
  } in_t;

  typedef struct {
    bit         rb;
    in_t        in;
    int         w, d, t;
    logic [3:0] e;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  wb_fairness_monitor_if #(.ADR_W(ADR_W), .DAT_W(DAT_W), .SEL_W(SEL_W)) bus_if ();
  logic              rvfi_valid, rvfi_trap;
  logic [31:0]       rvfi_insn;
  logic [CNT_W-1:0]  wait_cnt;
  logic [NEST_W-1:0] nest_depth;
  logic [TXN_W-1:0]  txn_count;
  logic              err_timeout, err_early_ack, err_unstable, err_nest;

  wb_fairness_monitor #(
    .ADR_W(ADR_W), .DAT_W(DAT_W), .SEL_W(SEL_W), .CNT_W(CNT_W), .MIN_LAT(MIN_LAT),
    .MAX_WAIT(MAX_WAIT), .NEST_W(NEST_W), .MAX_NEST(MAX_NEST), .TXN_W(TXN_W)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus_if),
    .rvfi_valid(rvfi_valid), .rvfi_trap(rvfi_trap), .rvfi_insn(rvfi_insn),
    .wait_cnt(wait_cnt), .nest_depth(nest_depth), .txn_count(txn_count),
    .err_timeout(err_timeout), .err_early_ack(err_early_ack),
    .err_unstable(err_unstable), .err_nest(err_nest)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a pending request, how long it has waited, and what it looked like.
  bit          m_pend;
  int          m_wait, m_txn, m_depth;
  bit          m_to, m_ea, m_un, m_ne;
  logic [29:0] c_adr;
  logic        c_we;
  logic [3:0]  c_sel;
  logic [31:0] c_dat;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = 0; m_wait = 0; m_txn = 0; m_depth = 0;
    m_to = 0; m_ea = 0; m_un = 0; m_ne = 0;
    c_adr = '0; c_we = 0; c_sel = '0; c_dat = '0;
  endtask

  task automatic model_step(input in_t i);
    bit req;
    req = i.cyc && i.stb;
    if (i.ack && (!req || m_wait < MIN_LAT)) m_ea = 1;
    if (req && !i.ack && (m_wait + 1 == MAX_WAIT)) m_to = 1;
    if (m_pend && req && (i.adr != c_adr || i.we != c_we || i.sel != c_sel ||
                          (i.we && i.dat != c_dat))) m_un = 1;
    if (req && i.ack) begin
      m_txn = (m_txn + 1) % (1 << TXN_W);
      m_wait = 0;
      m_pend = 0;
    end else if (req) begin
      if (!m_pend) begin
        c_adr = i.adr; c_we = i.we; c_sel = i.sel; c_dat = i.dat;
      end
      m_pend = 1;
      if (m_wait < (1 << CNT_W) - 1) m_wait++;
    end else begin
      m_pend = 0;
      m_wait = 0;
    end
    if (i.valid) begin
      if (i.trap) begin
        if (m_depth == MAX_NEST) m_ne = 1;
        else m_depth++;
      end else if (i.insn == MRET && m_depth > 0) begin
        m_depth--;
      end
    end
  endtask

  task automatic compare_model();
    check("model wait_cnt", int'(wait_cnt), m_wait);
    check("model nest_depth", int'(nest_depth), m_depth);
    check("model txn_count", int'(txn_count), m_txn);
    check("model err_timeout", int'(err_timeout), int'(m_to));
    check("model err_early_ack", int'(err_early_ack), int'(m_ea));
    check("model err_unstable", int'(err_unstable), int'(m_un));
    check("model err_nest", int'(err_nest), int'(m_ne));
  endtask

  task automatic apply(input in_t i);
    bus_if.cyc = i.cyc; bus_if.stb = i.stb; bus_if.we = i.we; bus_if.sel = i.sel;
    bus_if.adr = i.adr; bus_if.dat_w = i.dat; bus_if.ack = i.ack;
    rvfi_valid = i.valid; rvfi_trap = i.trap; rvfi_insn = i.insn;
  endtask

  function automatic in_t bi(logic cyc, logic stb, logic we, logic [29:0] adr,
                             logic [31:0] dat, logic ack);
    in_t r;
    r.cyc = cyc; r.stb = stb; r.we = we; r.sel = 4'hF; r.adr = adr; r.dat = dat; r.ack = ack;
    r.valid = 0; r.trap = 0; r.insn = NOP;
    return r;
  endfunction

  function automatic in_t ri(logic valid, logic trap, logic [31:0] insn);
    in_t r;
    r = bi(0, 0, 0, '0, '0, 0);
    r.valid = valid; r.trap = trap; r.insn = insn;
    return r;
  endfunction

  function automatic vec_t mk(bit rb, in_t in, int w, int d, int t, logic [3:0] e);
    vec_t v;
    v.rb = rb; v.in = in; v.w = w; v.d = d; v.t = t; v.e = e;
    return v;
  endfunction

  task automatic cycle(input in_t i);
    @(negedge clk);
    apply(i);
    model_step(i);
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic do_reset();
    @(negedge clk);
    apply(bi(0, 0, 0, '0, '0, 0));
    rst = 1'b0;
    #1;
    model_reset();
    compare_model();
    #1 rst = 1'b1;
  endtask

  vec_t vec[29];
  in_t  r_in;

  initial begin
    apply(bi(0, 0, 0, '0, '0, 0));
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();

    // {timeout, early_ack, unstable, nest}
    vec[0]  = mk(1, bi(1, 1, 0, 30'h100, 32'h0, 0), 1, 0, 0, 4'b0000);
    vec[1]  = mk(0, bi(1, 1, 0, 30'h100, 32'h0, 0), 2, 0, 0, 4'b0000);
    vec[2]  = mk(0, bi(1, 1, 0, 30'h100, 32'h0, 1), 0, 0, 1, 4'b0000);
    vec[3]  = mk(0, bi(0, 0, 0, 30'h0, 32'h0, 0),   0, 0, 1, 4'b0000);
    vec[4]  = mk(0, bi(1, 1, 0, 30'h200, 32'h0, 1), 0, 0, 2, 4'b0100);
    vec[5]  = mk(1, bi(1, 1, 1, 30'h300, 32'h1234, 0), 1, 0, 0, 4'b0000);
    vec[6]  = mk(0, bi(1, 1, 1, 30'h300, 32'h1234, 0), 2, 0, 0, 4'b0000);
    vec[7]  = mk(0, bi(1, 1, 1, 30'h300, 32'h1234, 0), 3, 0, 0, 4'b0000);
    vec[8]  = mk(0, bi(1, 1, 1, 30'h300, 32'h1234, 0), 4, 0, 0, 4'b1000);
    vec[9]  = mk(0, bi(1, 1, 1, 30'h300, 32'h1234, 1), 0, 0, 1, 4'b1000);
    vec[10] = mk(1, bi(1, 1, 0, 30'h10, 32'h0, 0),  1, 0, 0, 4'b0000);
    vec[11] = mk(0, bi(1, 1, 0, 30'h10, 32'h0, 1),  0, 0, 1, 4'b0000);
    vec[12] = mk(1, bi(1, 1, 0, 30'h100, 32'hAAAA, 0), 1, 0, 0, 4'b0000);
    vec[13] = mk(0, bi(1, 1, 0, 30'h100, 32'h5555, 0), 2, 0, 0, 4'b0000);
    vec[14] = mk(0, bi(1, 1, 0, 30'h104, 32'h5555, 0), 3, 0, 0, 4'b0010);
    vec[15] = mk(0, bi(0, 0, 0, 30'h0, 32'h0, 0),      0, 0, 0, 4'b0010);
    vec[16] = mk(1, bi(1, 1, 1, 30'h40, 32'h1, 0),     1, 0, 0, 4'b0000);
    vec[17] = mk(0, bi(1, 1, 1, 30'h40, 32'h2, 1),     0, 0, 1, 4'b0010);
    vec[18] = mk(1, bi(1, 1, 0, 30'h8, 32'h0, 0),      1, 0, 0, 4'b0000);
    vec[19] = mk(0, bi(1, 0, 0, 30'h8, 32'h0, 0),      0, 0, 0, 4'b0000);
    vec[20] = mk(1, ri(1, 1, NOP),  0, 1, 0, 4'b0000);
    vec[21] = mk(0, ri(1, 1, NOP),  0, 1, 0, 4'b0001);
    vec[22] = mk(0, ri(1, 0, MRET), 0, 0, 0, 4'b0001);
    vec[23] = mk(0, ri(1, 0, MRET), 0, 0, 0, 4'b0001);
    vec[24] = mk(0, ri(0, 1, NOP),  0, 0, 0, 4'b0001);
    vec[25] = mk(1, ri(1, 1, MRET), 0, 1, 0, 4'b0000);
    vec[26] = mk(0, ri(0, 0, MRET), 0, 1, 0, 4'b0000);
    vec[27] = mk(1, bi(0, 1, 0, 30'h0, 32'h0, 1), 0, 0, 0, 4'b0100);
    vec[28] = mk(1, bi(1, 0, 0, 30'h0, 32'h0, 1), 0, 0, 0, 4'b0100);

    foreach (vec[k]) begin
      if (vec[k].rb) do_reset();
      cycle(vec[k].in);
      check($sformatf("vec%0d wait_cnt", k), int'(wait_cnt), vec[k].w);
      check($sformatf("vec%0d nest_depth", k), int'(nest_depth), vec[k].d);
      check($sformatf("vec%0d txn_count", k), int'(txn_count), vec[k].t);
      check($sformatf("vec%0d flags", k),
            int'({err_timeout, err_early_ack, err_unstable, err_nest}), int'(vec[k].e));
    end

    // Reset in the middle of a pending strobe.
    do_reset();
    repeat (3) cycle(bi(1, 1, 0, 30'h55, 32'h0, 0));
    check("midrst wait before", int'(wait_cnt), 3);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst wait async", int'(wait_cnt), 0);
    check("midrst flags async",
          int'({err_timeout, err_early_ack, err_unstable, err_nest}), 0);
    model_reset();
    #1 rst = 1'b1;
    model_step(bi(1, 1, 0, 30'h55, 32'h0, 0));
    @(posedge clk);
    #1;
    compare_model();
    check("midrst wait restart", int'(wait_cnt), 1);

    // Sixteen clean transfers wrap the 4-bit transaction counter.
    do_reset();
    for (int n = 0; n < 16; n++) begin
      cycle(bi(1, 1, 0, 30'(n), 32'h0, 0));
      cycle(bi(1, 1, 0, 30'(n), 32'h0, 1));
    end
    check("wrap txn_count", int'(txn_count), 0);
    check("wrap flags", int'({err_timeout, err_early_ack, err_unstable, err_nest}), 0);

    // Randomized traffic against the model.
    do_reset();
    r_in = bi(0, 0, 0, '0, '0, 0);
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 79) == 0) do_reset();
      r_in.cyc = ($urandom_range(0, 7) != 0);
      r_in.stb = ($urandom_range(0, 3) != 0);
      r_in.ack = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) r_in.adr = 30'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) r_in.we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 31) == 0) r_in.sel = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) r_in.dat = $urandom;
      r_in.valid = ($urandom_range(0, 2) == 0);
      r_in.trap  = ($urandom_range(0, 3) == 0);
      r_in.insn  = ($urandom_range(0, 1) == 0) ? MRET : NOP;
      cycle(r_in);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
